// File: rtl/display_scan.sv
// Purpose : time-multiplexed scanner for a 4-digit display with a double-buffered digit word.
// Latency : a loaded word reaches the display at the next frame wrap; value/anodes follow idx with no extra cycle.
// Backpressure: none; loads are always accepted, and the last word loaded before a wrap wins.
//
// Ports:
//   clk, rst_n   - single clock, asynchronous active-low reset
//   enable       - 1 = scan and light digits, 0 = blank all anodes and freeze scanning
//   load         - one-cycle strobe capturing digits_in into the shadow register
//   digits_in    - four 2-bit digit codes, digit k at [2k+1:2k]
//   value        - 2-bit code of the currently selected digit
//   anodes       - active-low digit enables (bit k low lights digit k)
//   pending      - a captured word is waiting for the frame boundary
//   frame_done   - one-cycle pulse in the cycle after a 4-digit frame completes
module display_scan #(
    parameter int DIV = 50000,
    parameter int CW  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] digits_in,
    output logic [1:0] value,
    output logic [3:0] anodes,
    output logic       pending,
    output logic       frame_done
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    shadow;
    logic [7:0]    active;
    logic          tick;
    logic          wrap;

    // The prescaler only produces a tick while enabled, so disabling freezes
    // both the dwell count and the digit index exactly where they are.
    assign tick = enable && (cnt == LAST);
    assign wrap = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 8'h00;
            active     <= 8'h00;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (enable) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end

            if (tick) begin
                idx <= idx + 2'd1;
            end

            if (load) begin
                shadow <= digits_in;
            end

            // Transfer at the frame boundary only, so a word is never shown
            // half old / half new. A load on the same edge lands in shadow
            // and stays pending while active takes the previous shadow.
            if (wrap && pending) begin
                active <= shadow;
            end

            if (load) begin
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end

            frame_done <= wrap;
        end
    end

    // Outputs decode registered state only; digits_in and load never reach them.
    always_comb begin
        value = 2'b00;
        case (idx)
            2'd0: value = active[1:0];
            2'd1: value = active[3:2];
            2'd2: value = active[5:4];
            2'd3: value = active[7:6];
            default: value = 2'b00;
        endcase
    end

    assign anodes = enable ? ~(4'b0001 << idx) : 4'b1111;

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [7:0] digits_in;
    logic [1:0] value;
    logic [3:0] anodes;
    logic       pending;
    logic       frame_done;

    int checks = 0;
    int passed = 0;
    int k = 0;   // enabled clock edges since reset release

    display_scan #(.DIV(4), .CW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .value      (value),
        .anodes     (anodes),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic goto_k(input int target);
        while (k < target) adv(1);
    endtask

    // One snapshot of all outputs against hand-computed values.
    task automatic snap(input string tag, input logic [1:0] v, input logic [3:0] a,
                        input logic p, input logic f);
        chk({tag, ".value"},      {6'd0, value},      {6'd0, v});
        chk({tag, ".anodes"},     {4'd0, anodes},     {4'd0, a});
        chk({tag, ".pending"},    {7'd0, pending},    {7'd0, p});
        chk({tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, f});
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        load      = 1'b0;
        digits_in = 8'h00;

        // Reset state, before and after a clock edge.
        #2;
        snap("rst0", 2'd0, 4'b1110, 1'b0, 1'b0);
        @(posedge clk); #1;
        snap("rst1", 2'd0, 4'b1110, 1'b0, 1'b0);
        enable = 1'b0;
        #1;
        chk("rst_dis.anodes", {4'd0, anodes}, 8'h0F);
        enable = 1'b1;
        @(posedge clk); #1;

        // Basic scan: load E4 at idx 0.
        rst_n     = 1'b1;
        k         = 0;
        load      = 1'b1;
        digits_in = 8'hE4;
        adv(1);
        load = 1'b0;
        snap("b.k1", 2'd0, 4'b1110, 1'b1, 1'b0);
        goto_k(3);
        snap("b.k3", 2'd0, 4'b1110, 1'b1, 1'b0);
        goto_k(4);
        snap("b.k4", 2'd0, 4'b1101, 1'b1, 1'b0);
        goto_k(15);
        snap("b.k15", 2'd0, 4'b0111, 1'b1, 1'b0);
        goto_k(16);
        snap("b.wrap", 2'd0, 4'b1110, 1'b0, 1'b1);
        goto_k(17);
        snap("b.k17", 2'd0, 4'b1110, 1'b0, 1'b0);
        goto_k(20);
        snap("b.d1", 2'd1, 4'b1101, 1'b0, 1'b0);
        goto_k(23);
        snap("b.d1end", 2'd1, 4'b1101, 1'b0, 1'b0);
        goto_k(24);
        snap("b.d2", 2'd2, 4'b1011, 1'b0, 1'b0);
        goto_k(28);
        snap("b.d3", 2'd3, 4'b0111, 1'b0, 1'b0);
        goto_k(31);
        snap("b.k31", 2'd3, 4'b0111, 1'b0, 1'b0);
        goto_k(32);
        snap("b.wrap2", 2'd0, 4'b1110, 1'b0, 1'b1);

        // Mid-frame load of FF at idx 1.
        goto_k(36);
        load      = 1'b1;
        digits_in = 8'hFF;
        adv(1);
        load = 1'b0;
        snap("m.d1", 2'd1, 4'b1101, 1'b1, 1'b0);
        goto_k(40);
        snap("m.d2", 2'd2, 4'b1011, 1'b1, 1'b0);
        goto_k(44);
        snap("m.d3", 2'd3, 4'b0111, 1'b1, 1'b0);
        goto_k(48);
        snap("m.wrap", 2'd3, 4'b1110, 1'b0, 1'b1);

        // Simultaneous load and wrap: shadow=FF pending, load 00 on wrap tick.
        load      = 1'b1;
        digits_in = 8'hFF;
        adv(1);
        load = 1'b0;
        chk("s.pend_pre", {7'd0, pending}, 8'd1);
        goto_k(52);
        chk("s.val_pre", {6'd0, value}, 8'd3);
        goto_k(63);
        load      = 1'b1;
        digits_in = 8'h00;
        adv(1);
        load = 1'b0;
        snap("s.wrap", 2'd3, 4'b1110, 1'b1, 1'b1);
        goto_k(68);
        snap("s.d1", 2'd3, 4'b1101, 1'b1, 1'b0);
        goto_k(72);
        snap("s.d2", 2'd3, 4'b1011, 1'b1, 1'b0);
        goto_k(76);
        snap("s.d3", 2'd3, 4'b0111, 1'b1, 1'b0);
        goto_k(80);
        snap("s.wrap2", 2'd0, 4'b1110, 1'b0, 1'b1);
        goto_k(84);
        snap("s.n1", 2'd0, 4'b1101, 1'b0, 1'b0);

        // Enable gating at idx 2 with one dwell edge already spent; load while off.
        goto_k(89);
        enable = 1'b0;
        #1;
        snap("e.off", 2'd0, 4'b1111, 1'b0, 1'b0);
        load      = 1'b1;
        digits_in = 8'h55;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        snap("e.frozen", 2'd0, 4'b1111, 1'b1, 1'b0);
        enable = 1'b1;
        #1;
        chk("e.on.anodes", {4'd0, anodes}, {4'd0, 4'b1011});
        adv(2);
        chk("e.rem.anodes", {4'd0, anodes}, {4'd0, 4'b1011});
        adv(1);
        snap("e.d3", 2'd0, 4'b0111, 1'b1, 1'b0);
        goto_k(96);
        snap("e.wrap", 2'd1, 4'b1110, 1'b0, 1'b1);
        goto_k(100);
        snap("e.d1", 2'd1, 4'b1101, 1'b0, 1'b0);

        // Asynchronous reset pulse mid-frame while a word is pending.
        load      = 1'b1;
        digits_in = 8'hE4;
        adv(1);
        load = 1'b0;
        chk("r.pend_pre", {7'd0, pending}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        snap("r.async", 2'd0, 4'b1110, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        k = 0;
        adv(3);
        snap("r.d0end", 2'd0, 4'b1110, 1'b0, 1'b0);
        adv(1);
        snap("r.d1", 2'd0, 4'b1101, 1'b0, 1'b0);
        goto_k(16);
        snap("r.wrap", 2'd0, 4'b1110, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
